// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, counterpart of uart_tx at the same bit rate.
// Synchronises the asynchronous serial line, detects a start bit, samples
// eight data bits LSB-first at mid-bit and checks the stop bit.
//
// Parameters
//   CLKS_PER_BIT   clocks per serial bit (>= 4, must match the peer uart_tx)
// Ports
//   i_Clk          system clock, rising edge
//   i_Rst          asynchronous active-high reset
//   i_Rx_Serial    raw serial line, idle high, asynchronous to i_Clk
//   o_Rx_DV        one-cycle strobe: o_Rx_Byte holds a new good byte
//   o_Rx_Byte      last good byte; held until the next good byte
//   o_Rx_Frame_Err one-cycle strobe: stop bit sampled low
//   o_Rx_Active    high from start-bit detect until return to IDLE
module uart_rx #(
  parameter int CLKS_PER_BIT = 108
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Frame_Err,
  output logic       o_Rx_Active
);

  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4,
    BREAK   = 3'd5
  } state_t;

  state_t      r_State;
  logic        r_Rx_Meta;
  logic        r_Rx;
  logic [15:0] r_Clk_Count;
  logic [2:0]  r_Bit_Idx;
  logic [7:0]  r_Rx_Shift;

  // Two-flop synchroniser; idle level is high so reset preloads ones and a
  // reset cannot look like a start bit.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Rx_Meta <= 1'b1;
      r_Rx      <= 1'b1;
    end else begin
      r_Rx_Meta <= i_Rx_Serial;
      r_Rx      <= r_Rx_Meta;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State        <= IDLE;
      r_Clk_Count    <= '0;
      r_Bit_Idx      <= '0;
      r_Rx_Shift     <= '0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= '0;
      o_Rx_Frame_Err <= 1'b0;
      o_Rx_Active    <= 1'b0;
    end else begin
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;

      case (r_State)
        IDLE: begin
          r_Clk_Count <= '0;
          r_Bit_Idx   <= '0;
          o_Rx_Active <= 1'b0;
          if (!r_Rx) begin
            r_State     <= START;
            o_Rx_Active <= 1'b1;
          end
        end

        // Re-check the line half a bit in; a high here was a glitch.
        START: begin
          if (r_Clk_Count == HALF) begin
            r_Clk_Count <= '0;
            if (!r_Rx) begin
              r_State   <= DATA;
              r_Bit_Idx <= '0;
            end else begin
              r_State     <= IDLE;
              o_Rx_Active <= 1'b0;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

        DATA: begin
          if (r_Clk_Count == LAST) begin
            r_Clk_Count           <= '0;
            r_Rx_Shift[r_Bit_Idx] <= r_Rx;
            if (r_Bit_Idx == 3'd7) begin
              r_State <= STOP;
            end else begin
              r_Bit_Idx <= r_Bit_Idx + 3'd1;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

        STOP: begin
          if (r_Clk_Count == LAST) begin
            r_Clk_Count <= '0;
            if (r_Rx) begin
              o_Rx_Byte <= r_Rx_Shift;
              o_Rx_DV   <= 1'b1;
              r_State   <= CLEANUP;
            end else begin
              o_Rx_Frame_Err <= 1'b1;
              r_State        <= BREAK;
            end
          end else begin
            r_Clk_Count <= r_Clk_Count + 16'd1;
          end
        end

        CLEANUP: begin
          r_Clk_Count <= '0;
          r_State     <= IDLE;
          o_Rx_Active <= 1'b0;
        end

        // Wait for the line to go high so a held-low line (break) cannot
        // retrigger a start bit.
        BREAK: begin
          r_Clk_Count <= '0;
          if (r_Rx) begin
            r_State     <= IDLE;
            o_Rx_Active <= 1'b0;
          end
        end

        default: begin
          r_Clk_Count <= '0;
          r_State     <= IDLE;
          o_Rx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (8 clocks/bit) and a nominal
// instance (108 clocks/bit) driven by a bit-bang serial driver.
module tb_uart_rx;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       rx8, rx108;
  logic       dv8, fe8, act8;
  logic [7:0] byte8;
  logic       dv108, fe108, act108;
  logic [7:0] byte108;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;   // expected arrival cycle, -1 = don't care
  } exp_t;

  exp_t q8[$];
  exp_t q108[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int act8_total = 0;

  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(8)) dut8 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Rx_Serial(rx8),
    .o_Rx_DV(dv8), .o_Rx_Byte(byte8), .o_Rx_Frame_Err(fe8), .o_Rx_Active(act8)
  );

  uart_rx #(.CLKS_PER_BIT(108)) dut108 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Rx_Serial(rx108),
    .o_Rx_DV(dv108), .o_Rx_Byte(byte108), .o_Rx_Frame_Err(fe108), .o_Rx_Active(act108)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expected event per output strobe.
  always @(negedge i_Clk) begin
    if (act8) act8_total++;
    if (dv8 || fe8) begin
      check("dv_fe_exclusive8", 32'(dv8 && fe8), 0);
      check("event_expected8", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) begin
        exp_t e;
        e = q8.pop_front();
        check("event_kind8", 32'(fe8), 32'(e.err));
        check("rx_byte8", 32'(byte8), 32'(e.data));
        if (e.cyc >= 0) check("latency8", cyc, e.cyc);
      end
    end
  end

  always @(negedge i_Clk) begin
    if (dv108 || fe108) begin
      check("dv_fe_exclusive108", 32'(dv108 && fe108), 0);
      check("event_expected108", 32'(q108.size() != 0), 1);
      if (q108.size() != 0) begin
        exp_t e;
        e = q108.pop_front();
        check("event_kind108", 32'(fe108), 32'(e.err));
        check("rx_byte108", 32'(byte108), 32'(e.data));
      end
    end
  end

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic drive(input bit which, input logic v, input int n);
    if (which) rx108 = v; else rx8 = v;
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic send_byte(input bit which, input logic [7:0] b, input logic stop, input int period);
    drive(which, 1'b0, period);
    for (int i = 0; i < 8; i++) drive(which, b[i], period);
    drive(which, stop, period);
  endtask

  task automatic push8(input bit err, input logic [7:0] d, input int c);
    exp_t e;
    e.err = err; e.data = d; e.cyc = c;
    q8.push_back(e);
  endtask

  task automatic push108(input logic [7:0] d);
    exp_t e;
    e.err = 1'b0; e.data = d; e.cyc = -1;
    q108.push_back(e);
  endtask

  initial begin
    logic [7:0] b5a;
    int t0;
    i_Rst = 1'b1;
    rx8   = 1'b1;
    rx108 = 1'b1;
    repeat (4) @(posedge i_Clk);
    #1;
    // Reset values
    check("rst_dv8", 32'(dv8), 0);
    check("rst_byte8", 32'(byte8), 0);
    check("rst_fe8", 32'(fe8), 0);
    check("rst_active8", 32'(act8), 0);
    check("rst_dv108", 32'(dv108), 0);
    check("rst_byte108", 32'(byte108), 0);
    check("rst_fe108", 32'(fe108), 0);
    check("rst_active108", 32'(act108), 0);
    i_Rst = 1'b0;
    drive(0, 1'b1, 10);

    // 1: single byte with latency. Pin changes at cycle N; first sampling
    // edge is N+1, DV rises 78 clocks after that edge.
    push8(1'b0, 8'hA5, cyc + 79);
    send_byte(0, 8'hA5, 1'b1, 8);
    drive(0, 1'b1, 20);

    // 2: back-to-back frames
    push8(1'b0, 8'h00, -1);
    push8(1'b0, 8'hFF, -1);
    push8(1'b0, 8'h01, -1);
    send_byte(0, 8'h00, 1'b1, 8);
    send_byte(0, 8'hFF, 1'b1, 8);
    send_byte(0, 8'h01, 1'b1, 8);
    drive(0, 1'b1, 20);

    // 3: false start glitch
    t0 = act8_total;
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 30);
    check("glitch_active_1_to_7", 32'((act8_total - t0) > 0 && (act8_total - t0) < 8), 1);
    check("glitch_back_idle", 32'(act8), 0);

    // 4: framing error then break; byte keeps last good value 01
    push8(1'b1, 8'h01, -1);
    send_byte(0, 8'h3C, 1'b0, 8);
    drive(0, 1'b0, 30);
    check("break_holds_active", 32'(act8), 1);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 40);
    check("break_released_idle", 32'(act8), 0);
    check("byte_kept_after_err", 32'(byte8), 32'h01);

    // 5: reset during bit 4 of 5A, then 77
    b5a = 8'h5A;
    drive(0, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(0, b5a[i], 8);
    drive(0, b5a[4], 4);
    i_Rst = 1'b1;
    rx8   = 1'b1;
    repeat (3) @(posedge i_Clk);
    #1;
    check("midrst_dv8", 32'(dv8), 0);
    check("midrst_byte8", 32'(byte8), 0);
    check("midrst_fe8", 32'(fe8), 0);
    check("midrst_active8", 32'(act8), 0);
    i_Rst = 1'b0;
    drive(0, 1'b1, 20);
    check("post_rst_idle8", 32'(act8), 0);
    push8(1'b0, 8'h77, -1);
    send_byte(0, 8'h77, 1'b1, 8);
    drive(0, 1'b1, 20);

    // 6: 108 clocks/bit, peer at -2% and +2%
    push108(8'hC3);
    send_byte(1, 8'hC3, 1'b1, 106);
    drive(1, 1'b1, 300);
    push108(8'hC3);
    send_byte(1, 8'hC3, 1'b1, 110);
    drive(1, 1'b1, 300);

    for (int i = 0; i < 3000 && (q8.size() != 0 || q108.size() != 0); i++)
      @(posedge i_Clk);
    #1;
    check("q8_drained", q8.size(), 0);
    check("q108_drained", q108.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
